// File: rtl/riscv_lsu_if.sv
// Word-wide memory bus between the load/store unit and the memory system.
//
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_be/bus_wdata
// and holds all of them stable until it samples bus_ack=1 at a rising edge.
// The slave asserts bus_ack for exactly one cycle to complete the transfer.
// bus_rdata and bus_err are meaningful only in that bus_ack cycle. A request
// may be dropped without an ack (reset), and the slave must tolerate that.
interface riscv_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: turns one datapath load/store into one word-wide bus
// transaction with byte-lane steering, alignment checks and a bus timeout.
// The core is stalled from the request cycle until the bus acks; load data
// is returned right-justified and zero-filled in the following cycle.
module riscv_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_mem_op,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    output logic [31:0] mem_load_data,
    output logic        stall,
    output logic        misaligned_load,
    output logic        misaligned_store,
    output logic        access_fault,
    output logic [1:0]  dbg_state,
    riscv_lsu_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last counter value before the timeout fires; unused when TIMEOUT is 0.
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] load_q, load_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic [1:0]  size;
    logic [1:0]  off;
    logic        is_half;
    logic        is_word;
    logic        mis;
    logic        start;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_shift;
    logic [31:0] load_val;

    assign size    = mem_op[1:0];
    assign off     = mem_addr[1:0];
    assign is_half = (size == 2'b10);
    assign is_word = (size == 2'b11);
    assign mis     = (is_half & off[0]) | (is_word & (off != 2'b00));
    assign start   = is_mem_op & (size != 2'b00) & ~mis;

    // Lane steering: replicate the store data across the word and select lanes.
    always_comb begin
        be_new    = 4'b0000;
        wdata_new = mem_store_data;
        case (size)
            2'b01: begin
                be_new    = 4'b0001 << off;
                wdata_new = {4{mem_store_data[7:0]}};
            end
            2'b10: begin
                be_new    = 4'b0011 << {off[1], 1'b0};
                wdata_new = {2{mem_store_data[15:0]}};
            end
            2'b11: begin
                be_new    = 4'b1111;
                wdata_new = mem_store_data;
            end
            default: begin
                be_new    = 4'b0000;
                wdata_new = mem_store_data;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down and mask to the access size.
    always_comb begin
        rdata_shift = bus.bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b01:   load_val = {24'h0, rdata_shift[7:0]};
            2'b10:   load_val = {16'h0, rdata_shift[15:0]};
            default: load_val = rdata_shift;
        endcase
    end

    // FSM next state, timeout counter, fault flag, load capture and stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        load_d  = load_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = start;
                cnt_d = 32'd0;
                if (start) begin
                    state_d = S_REQ;
                    fault_d = 1'b0;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + 32'd1;
                // An ack in the same cycle as the timeout wins.
                if (bus.bus_ack) begin
                    state_d = S_DONE;
                    fault_d = bus.bus_err;
                    load_d  = (bus.bus_err | we_q) ? 32'd0 : load_val;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    load_d  = 32'd0;
                end
            end
            S_DONE: begin
                // The stalled instruction retires here; its is_mem_op is not a new request.
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // FSM state, counter, fault flag and load data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            fault_q <= 1'b0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            load_q  <= load_d;
        end
    end

    // Request registers: latched on start so bus outputs stay stable in S_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
        end else if ((state_q == S_IDLE) && start) begin
            addr_q  <= {mem_addr[31:2], 2'b00};
            we_q    <= mem_op[2];
            be_q    <= be_new;
            wdata_q <= wdata_new;
            size_q  <= size;
            off_q   <= off;
        end
    end

    assign bus.bus_req   = (state_q == S_REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    assign mem_load_data    = load_q;
    assign access_fault     = (state_q == S_DONE) & fault_q;
    assign misaligned_load  = (state_q == S_IDLE) & is_mem_op & mis & ~mem_op[2];
    assign misaligned_store = (state_q == S_IDLE) & is_mem_op & mis & mem_op[2];
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: the bench plays the memory bus and checks
// lanes, latency, alignment, timeout, bus errors, reset and back-to-back loads.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        is_mem_op = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_store_data = 32'h0;
    logic [31:0] mem_load_data;
    logic        stall;
    logic        misaligned_load;
    logic        misaligned_store;
    logic        access_fault;
    logic [1:0]  dbg_state;

    int tests = 0;
    int failed = 0;
    int txn_cnt = 0;

    // Results of the last do_access call.
    int          r_stall;
    int          r_req;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_ld;
    logic        r_flt;
    logic        r_done;

    riscv_lsu_if bus_if ();

    riscv_lsu #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .is_mem_op        (is_mem_op),
        .mem_op           (mem_op),
        .mem_addr         (mem_addr),
        .mem_store_data   (mem_store_data),
        .mem_load_data    (mem_load_data),
        .stall            (stall),
        .misaligned_load  (misaligned_load),
        .misaligned_store (misaligned_store),
        .access_fault     (access_fault),
        .dbg_state        (dbg_state),
        .bus              (bus_if)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Completed bus transactions.
    always @(posedge clk) begin
        if (bus_if.bus_req && bus_if.bus_ack) txn_cnt <= txn_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_tick();
        @(posedge clk);
        #1;
    endtask

    // One access from the request cycle to S_DONE; the bench acks after
    // 'waits' cycles of bus_req (waits < 0: never acks). Ends in the S_DONE cycle.
    task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input int waits,
                             input logic [31:0] rd, input logic err,
                             input logic hold_next);
        int w;
        r_stall = 0; r_req = 0; r_be = 4'h0; r_wdata = 32'h0; r_addr = 32'h0;
        r_we = 1'b0; r_ld = 32'h0; r_flt = 1'b0; r_done = 1'b0;
        w = 0;
        is_mem_op = 1'b1; mem_op = op; mem_addr = addr; mem_store_data = wd;
        #1;
        if (stall) r_stall++;
        for (int c = 0; c < 40 && !r_done; c++) begin
            @(posedge clk);
            #1;
            bus_if.bus_ack = 1'b0;
            bus_if.bus_err = 1'b0;
            if (bus_if.bus_req) begin
                if (r_req == 0) begin
                    r_be = bus_if.bus_be; r_wdata = bus_if.bus_wdata;
                    r_addr = bus_if.bus_addr; r_we = bus_if.bus_we;
                end
                r_req++;
                if (waits >= 0 && w == waits) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_rdata = rd;
                    bus_if.bus_err = err;
                end
                w++;
                #1;
                if (stall) r_stall++;
            end else begin
                is_mem_op = hold_next;
                #1;
                if (stall) r_stall++;
                r_ld = mem_load_data;
                r_flt = access_fault;
                r_done = 1'b1;
            end
        end
    endtask

    initial begin
        int seen;
        int txn0;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_err = 1'b0;
        bus_if.bus_rdata = 32'h0;

        // Reset state.
        #2 rst_n = 1'b0;
        idle_tick();
        idle_tick();
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_if.bus_be), 32'h0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst_load_data", mem_load_data, 32'h0);
        chk("rst_fault", 32'(access_fault), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        idle_tick();

        // Byte store @0x1003, ack after two wait cycles.
        do_access(3'b101, 32'h0000_1003, 32'h0000_00A5, 2, 32'h0, 1'b0, 1'b0);
        chk("sb_done", 32'(r_done), 32'd1);
        chk("sb_be", 32'(r_be), 32'h8);
        chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", r_addr, 32'h0000_1000);
        chk("sb_we", 32'(r_we), 32'd1);
        chk("sb_stall_cycles", r_stall, 4);
        chk("sb_req_cycles", r_req, 3);
        chk("sb_fault", 32'(r_flt), 32'd0);
        idle_tick();

        // Half load @0x2002, same-cycle ack.
        do_access(3'b010, 32'h0000_2002, 32'h0, 0, 32'hBEEF_1234, 1'b0, 1'b0);
        chk("lh_done", 32'(r_done), 32'd1);
        chk("lh_data", r_ld, 32'h0000_BEEF);
        chk("lh_be", 32'(r_be), 32'hC);
        chk("lh_we", 32'(r_we), 32'd0);
        chk("lh_stall_cycles", r_stall, 2);
        idle_tick();

        // Byte load @0x4001 picks lane 1.
        do_access(3'b001, 32'h0000_4001, 32'h0, 1, 32'h1122_3344, 1'b0, 1'b0);
        chk("lb_data", r_ld, 32'h0000_0033);
        chk("lb_be", 32'(r_be), 32'h2);
        chk("lb_stall_cycles", r_stall, 3);
        idle_tick();

        // Half store @0x6002 uses the upper lanes.
        do_access(3'b110, 32'h0000_6002, 32'hFFFF_1234, 0, 32'h0, 1'b0, 1'b0);
        chk("sh_be", 32'(r_be), 32'hC);
        chk("sh_wdata", r_wdata, 32'h1234_1234);
        chk("sh_load_zero", r_ld, 32'h0);
        idle_tick();

        // Word load @0x5000.
        do_access(3'b011, 32'h0000_5000, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("lw_data", r_ld, 32'hCAFE_F00D);
        chk("lw_be", 32'(r_be), 32'hF);
        idle_tick();
        chk("lw_data_held", mem_load_data, 32'hCAFE_F00D);

        // Misaligned word load: flag only, no stall, no bus request.
        is_mem_op = 1'b1; mem_op = 3'b011; mem_addr = 32'h0000_3001;
        #1;
        chk("mis_ld_flag", 32'(misaligned_load), 32'd1);
        chk("mis_ld_store_flag", 32'(misaligned_store), 32'd0);
        chk("mis_ld_stall", 32'(stall), 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            if (bus_if.bus_req) seen++;
        end
        chk("mis_ld_no_req", seen, 0);
        mem_op = 3'b110; mem_addr = 32'h0000_3003;
        #1;
        chk("mis_st_flag", 32'(misaligned_store), 32'd1);
        chk("mis_st_load_flag", 32'(misaligned_load), 32'd0);
        chk("mis_st_stall", 32'(stall), 32'd0);

        // Size 00 is a no-op.
        mem_op = 3'b100; mem_addr = 32'h0000_3001;
        #1;
        chk("noop_stall", 32'(stall), 32'd0);
        chk("noop_flags", 32'({misaligned_load, misaligned_store}), 32'd0);
        idle_tick();
        chk("noop_state", 32'(dbg_state), 32'd0);
        is_mem_op = 1'b0;
        idle_tick();

        // Timeout: no ack, bus_req held for TIMEOUT cycles, then a fault pulse.
        do_access(3'b011, 32'h0000_7000, 32'h0, -1, 32'h0, 1'b0, 1'b0);
        chk("to_done", 32'(r_done), 32'd1);
        chk("to_req_cycles", r_req, 4);
        chk("to_fault", 32'(r_flt), 32'd1);
        chk("to_load_zero", r_ld, 32'h0);
        chk("to_stall_cycles", r_stall, 5);
        idle_tick();
        chk("to_fault_pulse", 32'(access_fault), 32'd0);

        // Bus error with ack gives the same fault.
        do_access(3'b001, 32'h0000_8000, 32'h0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("err_fault", 32'(r_flt), 32'd1);
        chk("err_load_zero", r_ld, 32'h0);
        chk("err_req_cycles", r_req, 2);
        idle_tick();

        // Reset in the middle of S_REQ drops the request at once.
        is_mem_op = 1'b1; mem_op = 3'b011; mem_addr = 32'h0000_9000;
        idle_tick();
        chk("rstmid_req_before", 32'(bus_if.bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_req_dropped", 32'(bus_if.bus_req), 32'd0);
        chk("rstmid_state", 32'(dbg_state), 32'd0);
        is_mem_op = 1'b0;
        idle_tick();
        rst_n = 1'b1;
        idle_tick();
        do_access(3'b111, 32'h0000_A004, 32'h1357_9BDF, 1, 32'h0, 1'b0, 1'b0);
        chk("rstmid_new_done", 32'(r_done), 32'd1);
        chk("rstmid_new_addr", r_addr, 32'h0000_A004);
        chk("rstmid_new_wdata", r_wdata, 32'h1357_9BDF);
        chk("rstmid_new_fault", 32'(r_flt), 32'd0);
        idle_tick();

        // Back-to-back loads: is_mem_op held through S_DONE, two transactions only.
        txn0 = txn_cnt;
        do_access(3'b011, 32'h0000_B000, 32'h0, 0, 32'h0102_0304, 1'b0, 1'b1);
        chk("b2b_first_data", r_ld, 32'h0102_0304);
        idle_tick();
        do_access(3'b011, 32'h0000_B000, 32'h0, 0, 32'h0506_0708, 1'b0, 1'b0);
        chk("b2b_second_data", r_ld, 32'h0506_0708);
        chk("b2b_second_stall", r_stall, 2);
        idle_tick();
        idle_tick();
        idle_tick();
        chk("b2b_txn_count", txn_cnt - txn0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
